// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter: shares one single-port memory bus between the instruction-fetch (I) and data (D) masters.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority with D ahead of I.
module riscv_bus_arbiter #(
  parameter int OUTST_DEPTH = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_i_req,
  input  logic [AW-1:0]   i_i_addr,
  output logic            o_i_gnt,
  output logic            o_i_rvalid,
  output logic [DW-1:0]   o_i_rdata,
  input  logic            i_d_req,
  input  logic            i_d_we,
  input  logic [DW/8-1:0] i_d_be,
  input  logic [AW-1:0]   i_d_addr,
  input  logic [DW-1:0]   i_d_wdata,
  output logic            o_d_gnt,
  output logic            o_d_rvalid,
  output logic [DW-1:0]   o_d_rdata,
  output logic            o_s_req,
  output logic            o_s_we,
  output logic [DW/8-1:0] o_s_be,
  output logic [AW-1:0]   o_s_addr,
  output logic [DW-1:0]   o_s_wdata,
  input  logic            i_s_gnt,
  input  logic            i_s_rvalid,
  input  logic [DW-1:0]   i_s_rdata,
  output logic            o_err
);

  localparam int PW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int CW = $clog2(OUTST_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTST_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTST_DEPTH);

  // Handshake: a request is transferred in the cycle where req && gnt are both high; the requester
  // holds req and payload stable until then. Responses are single-cycle rvalid pulses, in request order.
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} portSel;
  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCK_I = 2'd1, LOCK_D = 2'd2} lockState_t;

  lockState_t      lockState, lockNext;
  portSel          owner;
  logic            ownerReq, full, grant, pop, stray, headId;
  logic [OUTST_DEPTH-1:0] idFifo;
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   count;
  logic            errSticky;
`ifdef ARB_ROUND_ROBIN_EN
  portSel          rrPtr;
`endif

  // A locked owner keeps the slave-side payload stable until its grant lands.
  always_comb begin
    owner = PORT_I;
    unique case (lockState)
      LOCK_I: owner = PORT_I;
      LOCK_D: owner = PORT_D;
      default: begin
        if (i_i_req && i_d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          owner = rrPtr;
`else
          owner = PORT_D;
`endif
        end else if (i_d_req) begin
          owner = PORT_D;
        end
      end
    endcase
  end

  assign ownerReq = (owner == PORT_D) ? i_d_req : i_i_req;
  assign full     = (count == FULL_CNT);
  assign o_s_req  = ownerReq && !full;
  assign grant    = o_s_req && i_s_gnt;
  assign o_i_gnt  = grant && (owner == PORT_I);
  assign o_d_gnt  = grant && (owner == PORT_D);

  assign o_s_we    = (owner == PORT_D) ? i_d_we    : 1'b0;
  assign o_s_be    = (owner == PORT_D) ? i_d_be    : '1;
  assign o_s_addr  = (owner == PORT_D) ? i_d_addr  : i_i_addr;
  assign o_s_wdata = (owner == PORT_D) ? i_d_wdata : '0;

  always_comb begin
    lockNext = UNLOCKED;
    if (ownerReq && !grant) begin
      lockNext = (owner == PORT_D) ? LOCK_D : LOCK_I;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockState <= UNLOCKED;
    end else begin
      lockState <= lockNext;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr <= PORT_I;
    end else if (grant) begin
      rrPtr <= (owner == PORT_D) ? PORT_I : PORT_D;
    end
  end
`endif

  // Responses with nothing outstanding are dropped and flagged.
  assign pop    = i_s_rvalid && (count != '0);
  assign stray  = i_s_rvalid && (count == '0);
  assign headId = idFifo[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idFifo    <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      errSticky <= 1'b0;
    end else begin
      if (grant) begin
        idFifo[wrPtr] <= owner;
        wrPtr         <= (wrPtr == LAST_PTR) ? '0 : wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + PW'(1);
      end
      if (grant && !pop) begin
        count <= count + CW'(1);
      end else if (!grant && pop) begin
        count <= count - CW'(1);
      end
      if (stray) begin
        errSticky <= 1'b1;
      end
    end
  end

  assign o_i_rvalid = pop && (headId == PORT_I);
  assign o_d_rvalid = pop && (headId == PORT_D);
  assign o_i_rdata  = i_s_rdata;
  assign o_d_rdata  = i_s_rdata;
  assign o_err      = errSticky;

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// tb_riscv_bus_arbiter: directed and randomised checks of grant, lock, full and response routing.
// Expected arbitration order follows ARB_ROUND_ROBIN_EN when that macro is defined.
module tb_riscv_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 2;
  localparam int EW = DW + 1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic FIRST_D = 1'b0;
`else
  localparam logic FIRST_D = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_i_req, o_i_gnt, o_i_rvalid;
  logic [AW-1:0] i_i_addr;
  logic [DW-1:0] o_i_rdata;
  logic i_d_req, i_d_we, o_d_gnt, o_d_rvalid;
  logic [DW/8-1:0] i_d_be;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata, o_d_rdata;
  logic o_s_req, o_s_we;
  logic [DW/8-1:0] o_s_be;
  logic [AW-1:0] o_s_addr;
  logic [DW-1:0] o_s_wdata;
  logic i_s_gnt, i_s_rvalid;
  logic [DW-1:0] i_s_rdata;
  logic o_err;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] slave_q[$];

  riscv_bus_arbiter #(.OUTST_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_i_req(i_i_req), .i_i_addr(i_i_addr), .o_i_gnt(o_i_gnt),
    .o_i_rvalid(o_i_rvalid), .o_i_rdata(o_i_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_be(i_d_be), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_s_req(o_s_req), .o_s_we(o_s_we), .o_s_be(o_s_be), .o_s_addr(o_s_addr),
    .o_s_wdata(o_s_wdata), .i_s_gnt(i_s_gnt), .i_s_rvalid(i_s_rvalid),
    .i_s_rdata(i_s_rdata), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_i_req = 0; i_i_addr = '0;
    i_d_req = 0; i_d_we = 0; i_d_be = '0; i_d_addr = '0; i_d_wdata = '0;
    i_s_gnt = 0; i_s_rvalid = 0; i_s_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    exp_q.delete();
    slave_q.delete();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic push_resp(input logic port);
    logic [DW-1:0] d;
    d = $urandom();
    slave_q.push_back(d);
    exp_q.push_back({port, d});
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    checks++;
    if ({o_i_gnt, o_d_gnt, o_i_rvalid, o_d_rvalid, o_s_req, o_err} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 000000",
        {o_i_gnt, o_d_gnt, o_i_rvalid, o_d_rvalid, o_s_req, o_err});
    end
    i_s_rvalid = 1;
    step();
    checks++;
    if ({o_i_rvalid, o_d_rvalid, o_err} !== 3'b000) begin
      errors++; $display("FAIL reset_hold: got %b want 000", {o_i_rvalid, o_d_rvalid, o_err});
    end
    i_s_rvalid = 0;
  endtask

  task automatic test_single_read();
    logic [EW-1:0] exp;
    apply_reset();
    i_i_req = 1; i_i_addr = 32'h100; i_s_gnt = 1;
    #1;
    checks++;
    if ({o_i_gnt, o_d_gnt, o_s_req} !== 3'b101) begin
      errors++; $display("FAIL single_gnt: got %b want 101", {o_i_gnt, o_d_gnt, o_s_req});
    end
    checks++;
    if ({o_s_we, o_s_be, o_s_addr} !== {1'b0, 4'hF, 32'h100}) begin
      errors++; $display("FAIL single_payload: got %h want %h", {o_s_we, o_s_be, o_s_addr}, {1'b0, 4'hF, 32'h100});
    end
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    step();
    i_i_req = 0; i_s_gnt = 0; i_s_rvalid = 1; i_s_rdata = 32'hDEADBEEF;
    #1;
    exp = exp_q.pop_front();
    checks++;
    if ({o_i_rvalid, o_d_rvalid} !== {~exp[DW], exp[DW]}) begin
      errors++; $display("FAIL single_route: got %b want %b", {o_i_rvalid, o_d_rvalid}, {~exp[DW], exp[DW]});
    end
    checks++;
    if (o_i_rdata !== exp[DW-1:0]) begin
      errors++; $display("FAIL single_rdata: got %h want %h", o_i_rdata, exp[DW-1:0]);
    end
    step();
    i_s_rvalid = 0;
    #1;
    checks++;
    if ({o_i_rvalid, o_d_rvalid} !== 2'b00) begin
      errors++; $display("FAIL single_after: got %b want 00", {o_i_rvalid, o_d_rvalid});
    end
  endtask

  task automatic drain_no_check();
    while (slave_q.size() > 0) begin
      i_s_rvalid = 1; i_s_rdata = slave_q.pop_front();
      step();
    end
    i_s_rvalid = 0;
  endtask

  task automatic test_priority();
    logic [EW-1:0] exp;
    apply_reset();
    i_i_req = 1; i_i_addr = 32'h200;
    i_d_req = 1; i_d_addr = 32'h300; i_d_we = 1; i_d_be = 4'b0011; i_d_wdata = 32'h12345678;
    i_s_gnt = 1;
    #1;
    checks++;
    if ({o_i_gnt, o_d_gnt} !== {~FIRST_D, FIRST_D}) begin
      errors++; $display("FAIL prio_first: got %b want %b", {o_i_gnt, o_d_gnt}, {~FIRST_D, FIRST_D});
    end
    checks++;
    if ({o_s_we, o_s_be, o_s_addr} !== (FIRST_D ? {1'b1, 4'b0011, 32'h300} : {1'b0, 4'hF, 32'h200})) begin
      errors++; $display("FAIL prio_payload: got %h", {o_s_we, o_s_be, o_s_addr});
    end
    push_resp(FIRST_D);
    step();
    if (FIRST_D) i_d_req = 0; else i_i_req = 0;
    #1;
    checks++;
    if ({o_i_gnt, o_d_gnt} !== {FIRST_D, ~FIRST_D}) begin
      errors++; $display("FAIL prio_second: got %b want %b", {o_i_gnt, o_d_gnt}, {FIRST_D, ~FIRST_D});
    end
    push_resp(~FIRST_D);
    step();
    idle_inputs();
    while (slave_q.size() > 0) begin
      i_s_rvalid = 1; i_s_rdata = slave_q.pop_front();
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({o_i_rvalid, o_d_rvalid} !== {~exp[DW], exp[DW]}) begin
        errors++; $display("FAIL prio_route: got %b want %b", {o_i_rvalid, o_d_rvalid}, {~exp[DW], exp[DW]});
      end
      checks++;
      if ((exp[DW] ? o_d_rdata : o_i_rdata) !== exp[DW-1:0]) begin
        errors++; $display("FAIL prio_rdata: want %h", exp[DW-1:0]);
      end
      step();
    end
    i_s_rvalid = 0;
  endtask

  task automatic test_lock();
    apply_reset();
    i_i_req = 1; i_i_addr = 32'h400; i_d_req = 1; i_d_addr = 32'h500;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({o_s_req, o_i_gnt, o_d_gnt, o_s_addr} !== {3'b100, (FIRST_D ? 32'h500 : 32'h400)}) begin
        errors++; $display("FAIL lock_hold%0d: got %h", k, {o_s_req, o_i_gnt, o_d_gnt, o_s_addr});
      end
      step();
    end
    i_s_gnt = 1;
    #1;
    checks++;
    if ({o_i_gnt, o_d_gnt} !== {~FIRST_D, FIRST_D}) begin
      errors++; $display("FAIL lock_release: got %b want %b", {o_i_gnt, o_d_gnt}, {~FIRST_D, FIRST_D});
    end
    push_resp(FIRST_D);
    step();
    idle_inputs();
    drain_no_check();
    exp_q.delete();

    // I waits alone, then D arrives: I must keep the bus despite D's priority.
    apply_reset();
    i_i_req = 1; i_i_addr = 32'h800;
    step();
    i_d_req = 1; i_d_addr = 32'h900;
    #1;
    checks++;
    if ({o_s_req, o_s_addr} !== {1'b1, 32'h800}) begin
      errors++; $display("FAIL lock_i_owner: got %h want %h", {o_s_req, o_s_addr}, {1'b1, 32'h800});
    end
    i_s_gnt = 1;
    #1;
    checks++;
    if ({o_i_gnt, o_d_gnt} !== 2'b10) begin
      errors++; $display("FAIL lock_i_gnt: got %b want 10", {o_i_gnt, o_d_gnt});
    end
    push_resp(1'b0);
    step();
    i_i_req = 0;
    #1;
    checks++;
    if ({o_d_gnt, o_s_addr} !== {1'b1, 32'h900}) begin
      errors++; $display("FAIL lock_d_next: got %h want %h", {o_d_gnt, o_s_addr}, {1'b1, 32'h900});
    end
    push_resp(1'b1);
    step();
    idle_inputs();
    drain_no_check();
    exp_q.delete();
  endtask

  task automatic test_full();
    logic [EW-1:0] exp;
    apply_reset();
    i_i_req = 1; i_s_gnt = 1;
    for (int k = 0; k < DEPTH; k++) begin
      i_i_addr = 32'h600 + 32'(4 * k);
      #1;
      checks++;
      if ({o_s_req, o_i_gnt} !== 2'b11) begin
        errors++; $display("FAIL full_fill%0d: got %b want 11", k, {o_s_req, o_i_gnt});
      end
      push_resp(1'b0);
      step();
    end
    i_i_addr = 32'h608;
    #1;
    checks++;
    if ({o_s_req, o_i_gnt} !== 2'b00) begin
      errors++; $display("FAIL full_block: got %b want 00", {o_s_req, o_i_gnt});
    end
    step();
    i_s_rvalid = 1; i_s_rdata = slave_q.pop_front();
    #1;
    exp = exp_q.pop_front();
    checks++;
    if ({o_s_req, o_i_gnt, o_i_rvalid, o_d_rvalid, o_i_rdata} !== {4'b0010, exp[DW-1:0]}) begin
      errors++; $display("FAIL full_pop_block: got %h want %h", {o_s_req, o_i_gnt, o_i_rvalid, o_d_rvalid, o_i_rdata}, {4'b0010, exp[DW-1:0]});
    end
    step();
    i_s_rdata = slave_q.pop_front();
    #1;
    exp = exp_q.pop_front();
    checks++;
    if ({o_s_req, o_i_gnt, o_s_addr} !== {2'b11, 32'h608}) begin
      errors++; $display("FAIL full_regrant: got %h", {o_s_req, o_i_gnt, o_s_addr});
    end
    checks++;
    if ({o_i_rvalid, o_i_rdata} !== {1'b1, exp[DW-1:0]}) begin
      errors++; $display("FAIL full_pushpop_resp: got %h want %h", {o_i_rvalid, o_i_rdata}, {1'b1, exp[DW-1:0]});
    end
    push_resp(1'b0);
    step();
    i_s_rvalid = 0; i_i_req = 0; i_d_req = 1; i_d_addr = 32'h700;
    #1;
    checks++;
    if (o_d_gnt !== 1'b1) begin
      errors++; $display("FAIL full_after_pushpop: got %b want 1", o_d_gnt);
    end
    push_resp(1'b1);
    step();
    idle_inputs();
    while (slave_q.size() > 0) begin
      i_s_rvalid = 1; i_s_rdata = slave_q.pop_front();
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({o_i_rvalid, o_d_rvalid} !== {~exp[DW], exp[DW]}) begin
        errors++; $display("FAIL full_wrap_route: got %b want %b", {o_i_rvalid, o_d_rvalid}, {~exp[DW], exp[DW]});
      end
      step();
    end
    i_s_rvalid = 0;
  endtask

  task automatic test_stray();
    apply_reset();
    i_s_rvalid = 1; i_s_rdata = 32'hBAD0BAD0;
    #1;
    checks++;
    if ({o_i_rvalid, o_d_rvalid} !== 2'b00) begin
      errors++; $display("FAIL stray_rvalid: got %b want 00", {o_i_rvalid, o_d_rvalid});
    end
    step();
    i_s_rvalid = 0;
    repeat (2) step();
    checks++;
    if (o_err !== 1'b1) begin
      errors++; $display("FAIL stray_err_sticky: got %b want 1", o_err);
    end
    rst_n = 0;
    #1;
    checks++;
    if (o_err !== 1'b0) begin
      errors++; $display("FAIL stray_err_reset: got %b want 0", o_err);
    end
    rst_n = 1;
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] exp;
    logic want_d;
    apply_reset();
    i_i_req = 1; i_i_addr = 32'h40; i_d_req = 1; i_d_addr = 32'h80; i_s_gnt = 1;
    for (int k = 0; k < 6; k++) begin
      want_d = FIRST_D ? 1'b1 : 1'(k % 2);
      i_s_rvalid = (slave_q.size() > 0);
      if (i_s_rvalid) i_s_rdata = slave_q.pop_front();
      #1;
      checks++;
      if ({o_i_gnt, o_d_gnt} !== {~want_d, want_d}) begin
        errors++; $display("FAIL b2b_gnt%0d: got %b want %b", k, {o_i_gnt, o_d_gnt}, {~want_d, want_d});
      end
      if (i_s_rvalid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({o_i_rvalid, o_d_rvalid} !== {~exp[DW], exp[DW]}) begin
          errors++; $display("FAIL b2b_route%0d: got %b want %b", k, {o_i_rvalid, o_d_rvalid}, {~exp[DW], exp[DW]});
        end
      end
      push_resp(want_d);
      step();
    end
    idle_inputs();
    drain_no_check();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [EW-1:0] exp;
    logic [DW-1:0] d;
    logic prev_wait, i_gnt, d_gnt;
    logic [AW-1:0] prev_addr;
    apply_reset();
    prev_wait = 0; prev_addr = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!i_i_req && $urandom_range(0, 2) == 0) begin
        i_i_req = 1; i_i_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!i_d_req && $urandom_range(0, 2) == 0) begin
        i_d_req = 1; i_d_we = 1'($urandom_range(0, 1)); i_d_be = 4'($urandom_range(1, 15));
        i_d_addr = $urandom(); i_d_wdata = $urandom();
      end
      i_s_gnt = ($urandom_range(0, 3) != 0);
      i_s_rvalid = (slave_q.size() > 0) && ($urandom_range(0, 2) == 0);
      if (i_s_rvalid) i_s_rdata = slave_q.pop_front();
      #1;
      checks++;
      if (o_i_gnt && o_d_gnt) begin
        errors++; $display("FAIL rand_dual_gnt: got 11 want not both at cycle %0d", cyc);
      end
      if (prev_wait) begin
        checks++;
        if ({o_s_req, o_s_addr} !== {1'b1, prev_addr}) begin
          errors++; $display("FAIL rand_stable: got %h want %h", {o_s_req, o_s_addr}, {1'b1, prev_addr});
        end
      end
      if (i_s_rvalid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({o_i_rvalid, o_d_rvalid, (exp[DW] ? o_d_rdata : o_i_rdata)} !== {~exp[DW], exp[DW], exp[DW-1:0]}) begin
          errors++; $display("FAIL rand_resp: got %b want %b", {o_i_rvalid, o_d_rvalid}, {~exp[DW], exp[DW]});
        end
      end else begin
        checks++;
        if ({o_i_rvalid, o_d_rvalid} !== 2'b00) begin
          errors++; $display("FAIL rand_idle_rvalid: got %b want 00", {o_i_rvalid, o_d_rvalid});
        end
      end
      if (o_i_gnt) begin
        checks++;
        if ({i_i_req, o_s_we, o_s_be, o_s_addr} !== {2'b10, 4'hF, i_i_addr}) begin
          errors++; $display("FAIL rand_i_payload: got %h", {i_i_req, o_s_we, o_s_be, o_s_addr});
        end
        d = $urandom(); slave_q.push_back(d); exp_q.push_back({1'b0, d});
      end
      if (o_d_gnt) begin
        checks++;
        if ({i_d_req, o_s_we, o_s_be, o_s_addr, o_s_wdata} !== {1'b1, i_d_we, i_d_be, i_d_addr, i_d_wdata}) begin
          errors++; $display("FAIL rand_d_payload: got %h", {o_s_we, o_s_be, o_s_addr, o_s_wdata});
        end
        d = $urandom(); slave_q.push_back(d); exp_q.push_back({1'b1, d});
      end
      prev_wait = o_s_req && !i_s_gnt;
      prev_addr = o_s_addr;
      i_gnt = o_i_gnt; d_gnt = o_d_gnt;
      step();
      if (i_gnt) i_i_req = 0;
      if (d_gnt) i_d_req = 0;
    end
    i_i_req = 0; i_d_req = 0; i_s_gnt = 0;
    for (int k = 0; k < 2 * DEPTH && slave_q.size() > 0; k++) begin
      i_s_rvalid = 1; i_s_rdata = slave_q.pop_front();
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({o_i_rvalid, o_d_rvalid} !== {~exp[DW], exp[DW]}) begin
        errors++; $display("FAIL rand_drain: got %b want %b", {o_i_rvalid, o_d_rvalid}, {~exp[DW], exp[DW]});
      end
      step();
    end
    i_s_rvalid = 0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_leftover: got %0d want 0 entries", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_lock();
    test_full();
    test_stray();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
